// File: rtl/exe_muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: radix-2 shift-add multiply and
// restoring divide over 32 cycles, with a 2-cycle path for divide-by-zero/overflow.
module exe_muldiv_seq #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [2:0]            muldiv_op,
   input  logic [DATA_WIDTH-1:0] rs1,
   input  logic [DATA_WIDTH-1:0] rs2,
   input  logic                  flush,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] result
);

   localparam int W = DATA_WIDTH;
   localparam logic [W-1:0] MIN_INT = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t         state_q, state_d;
   logic [2:0]     op_q, op_d;
   logic           neg_a_q, neg_a_d, neg_b_q, neg_b_d;
   logic [2*W-1:0] acc_q, acc_d;
   logic [W-1:0]   opnd_q, opnd_d;
   logic [4:0]     cnt_q, cnt_d;
   logic           fast_q, fast_d;
   logic [W-1:0]   fast_res_q, fast_res_d;
   logic [W-1:0]   result_q, result_d;

   logic           sgn_a, sgn_b, accept, rem_ge;
   logic [W-1:0]   mag_a, mag_b;
   logic [W:0]     add_sum, rem_sh, rem_sub;
   logic [2*W-1:0] prod;

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      neg_a_d    = neg_a_q;
      neg_b_d    = neg_b_q;
      acc_d      = acc_q;
      opnd_d     = opnd_q;
      cnt_d      = cnt_q;
      fast_d     = fast_q;
      fast_res_d = fast_res_q;
      result_d   = result_q;

      sgn_a = 1'b0;
      sgn_b = 1'b0;
      case (muldiv_op)
         3'b000, 3'b001, 3'b100, 3'b110: begin
            sgn_a = rs1[W-1];
            sgn_b = rs2[W-1];
         end
         3'b010:  sgn_a = rs1[W-1];
         default: ;
      endcase
      mag_a = sgn_a ? ('0 - rs1) : rs1;
      mag_b = sgn_b ? ('0 - rs2) : rs2;

      add_sum = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      rem_sh  = acc_q[2*W-1:W-1];
      rem_sub = rem_sh - {1'b0, opnd_q};
      rem_ge  = (rem_sh >= {1'b0, opnd_q});
      prod    = (neg_a_q ^ neg_b_q) ? ('0 - acc_q) : acc_q;

      accept = ((state_q == IDLE) || (state_q == DONE)) && start && !flush;

      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (accept) begin
               op_d    = muldiv_op;
               neg_a_d = sgn_a;
               neg_b_d = sgn_b;
               // Multiply: multiplier rides in the low half; divide: dividend does.
               acc_d   = {{W{1'b0}}, muldiv_op[2] ? mag_a : mag_b};
               opnd_d  = muldiv_op[2] ? mag_b : mag_a;
               cnt_d   = '0;
               fast_d  = 1'b0;
               state_d = CALC;
               if (muldiv_op[2] && (rs2 == '0)) begin
                  fast_d     = 1'b1;
                  fast_res_d = muldiv_op[1] ? rs1 : '1;
                  state_d    = FIX;
               end else if (muldiv_op[2] && !muldiv_op[0] &&
                            (rs1 == MIN_INT) && (rs2 == '1)) begin
                  fast_d     = 1'b1;
                  fast_res_d = muldiv_op[1] ? '0 : MIN_INT;
                  state_d    = FIX;
               end
            end
         end
         CALC: begin
            if (op_q[2])
               acc_d = {rem_ge ? rem_sub[W-1:0] : rem_sh[W-1:0], acc_q[W-2:0], rem_ge};
            else
               acc_d = {add_sum, acc_q[W-1:1]};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31)
               state_d = FIX;
         end
         FIX: begin
            if (fast_q)
               result_d = fast_res_q;
            else if (!op_q[2])
               result_d = (op_q == 3'b000) ? prod[W-1:0] : prod[2*W-1:W];
            else if (!op_q[1])
               result_d = (neg_a_q ^ neg_b_q) ? ('0 - acc_q[W-1:0]) : acc_q[W-1:0];
            else
               result_d = neg_a_q ? ('0 - acc_q[2*W-1:W]) : acc_q[2*W-1:W];
            state_d = DONE;
         end
         default: state_d = IDLE;
      endcase

      // A kill abandons the operation without touching the visible result.
      if (flush) begin
         state_d  = IDLE;
         result_d = result_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         op_q       <= '0;
         neg_a_q    <= 1'b0;
         neg_b_q    <= 1'b0;
         acc_q      <= '0;
         opnd_q     <= '0;
         cnt_q      <= '0;
         fast_q     <= 1'b0;
         fast_res_q <= '0;
         result_q   <= '0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         neg_a_q    <= neg_a_d;
         neg_b_q    <= neg_b_d;
         acc_q      <= acc_d;
         opnd_q     <= opnd_d;
         cnt_q      <= cnt_d;
         fast_q     <= fast_d;
         fast_res_q <= fast_res_d;
         result_q   <= result_d;
      end
   end

   assign busy   = (state_q == CALC) || (state_q == FIX) || accept;
   assign done   = (state_q == DONE);
   assign result = result_q;

endmodule

// File: tb/tb_exe_muldiv_seq.sv
// Bench for exe_muldiv_seq: directed cases plus random ops checked against an
// arithmetic reference model (64-bit products, native signed divide).
module tb_exe_muldiv_seq;

   logic        clk = 1'b0;
   logic        rst, start, flush;
   logic [2:0]  op;
   logic [31:0] a, b;
   logic        busy, done;
   logic [31:0] result;

   int checks = 0;
   int errors = 0;

   exe_muldiv_seq #(.DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .muldiv_op(op),
      .rs1(a), .rs2(b), .flush(flush),
      .busy(busy), .done(done), .result(result)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] x,
                                             input logic [31:0] y);
      int              sx, sy, q;
      longint          p;
      longint unsigned up;
      sx = x;
      sy = y;
      case (f)
         3'd0: begin p = longint'(sx) * longint'(sy); return p[31:0]; end
         3'd1: begin p = longint'(sx) * longint'(sy); return p[63:32]; end
         3'd2: begin p = longint'(sx) * longint'({32'h0, y}); return p[63:32]; end
         3'd3: begin up = {32'h0, x} * {32'h0, y}; return up[63:32]; end
         3'd4: begin
            if (y == 0) return 32'hFFFF_FFFF;
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
            q = sx / sy; return q;
         end
         3'd5: begin if (y == 0) return 32'hFFFF_FFFF; return x / y; end
         3'd6: begin
            if (y == 0) return x;
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
            q = sx % sy; return q;
         end
         default: begin if (y == 0) return x; return x % y; end
      endcase
   endfunction

   function automatic int ref_latency(input logic [2:0] f, input logic [31:0] x,
                                      input logic [31:0] y);
      if (f[2] && (y == 0 || (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)))
         return 2;
      return 34;
   endfunction

   // Called at negedge+1; raises start for the current cycle.
   task automatic start_op(input string tag, input logic [2:0] f, input logic [31:0] x,
                           input logic [31:0] y);
      op = f; a = x; b = y; start = 1'b1;
      #1;
      chk({tag, "_busy_start"}, {31'b0, busy}, 32'd1);
   endtask

   // Counts cycles from the start cycle (index 0) to the done cycle; returns in DONE.
   task automatic wait_done(input string tag, input logic [31:0] exp, input int lat);
      int cyc;
      bit busy_ok;
      busy_ok = 1'b1;
      @(posedge clk);
      @(negedge clk);
      #1;
      start = 1'b0;
      #1;
      cyc = 1;
      while (done !== 1'b1 && cyc < 100) begin
         if (busy !== 1'b1) busy_ok = 1'b0;
         @(negedge clk);
         #1;
         cyc++;
      end
      chk({tag, "_latency"}, 32'(cyc), 32'(lat));
      chk({tag, "_busy_held"}, {31'b0, busy_ok}, 32'd1);
      chk({tag, "_busy_in_done"}, {31'b0, busy}, 32'd0);
      chk({tag, "_result"}, result, exp);
      $display("op=%0d rs1=%h rs2=%h result=%h cycles=%0d", op, a, b, result, cyc);
   endtask

   task automatic next_cycle();
      @(negedge clk);
      #1;
   endtask

   // Watches n cycles for any done pulse.
   task automatic no_done_for(input string tag, input int n);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (done !== 1'b0) seen = 1'b1;
         next_cycle();
      end
      chk({tag, "_no_done"}, {31'b0, seen}, 32'd0);
   endtask

   logic [2:0]  d_op  [12] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                               3'd5, 3'd7, 3'd4, 3'd6};
   logic [31:0] d_a   [12] = '{32'd7, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF,
                               32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100,
                               32'd100, 32'd100, 32'h80000000, 32'h80000000};
   logic [31:0] d_b   [12] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF,
                               32'd2, 32'd2, 32'd7, 32'd7,
                               32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
   logic [31:0] d_exp [12] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'h40000000, 32'hFFFFFFFF,
                               32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2,
                               32'hFFFFFFFF, 32'd100, 32'h80000000, 32'd0};
   int          d_lat [12] = '{34, 34, 34, 34, 34, 34, 34, 34, 2, 2, 2, 2};

   initial begin
      logic [2:0]  rf;
      logic [31:0] rx, ry;
      int          mode;

      rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_busy", {31'b0, busy}, 32'd0);
      chk("reset_done", {31'b0, done}, 32'd0);
      chk("reset_result", result, 32'd0);
      rst = 1'b0;
      next_cycle();
      chk("idle_busy", {31'b0, busy}, 32'd0);

      for (int i = 0; i < 12; i++) begin
         start_op($sformatf("dir%0d", i), d_op[i], d_a[i], d_b[i]);
         wait_done($sformatf("dir%0d", i), d_exp[i], d_lat[i]);
         next_cycle();
         chk($sformatf("dir%0d_done_pulse", i), {31'b0, done}, 32'd0);
      end

      // Flush ten cycles into a divide
      start_op("pre_flush", 3'd5, 32'd1000, 32'd7);
      wait_done("pre_flush", 32'd142, 34);
      next_cycle();
      start_op("flush", 3'd4, 32'd12345, 32'd67);
      @(posedge clk);
      @(negedge clk);
      #1;
      start = 1'b0;
      repeat (9) next_cycle();
      flush = 1'b1;
      next_cycle();
      flush = 1'b0;
      chk("flush_busy", {31'b0, busy}, 32'd0);
      no_done_for("flush", 40);
      chk("flush_result_kept", result, 32'd142);
      $display("flush mid-divide: result=%h", result);

      start_op("after_flush", 3'd0, 32'd3, 32'd4);
      wait_done("after_flush", 32'd12, 34);
      next_cycle();

      // Flush and start together: the start must be dropped
      op = 3'd5; a = 32'd50; b = 32'd5; start = 1'b1; flush = 1'b1;
      #1;
      chk("flush_start_busy", {31'b0, busy}, 32'd0);
      next_cycle();
      start = 1'b0; flush = 1'b0;
      #1;
      chk("flush_start_busy_after", {31'b0, busy}, 32'd0);
      no_done_for("flush_start", 40);
      chk("flush_start_result", result, 32'd12);
      $display("flush+start: result=%h", result);

      // Back-to-back issue in the DONE cycle
      start_op("b2b_mul", 3'd0, 32'd2, 32'd3);
      wait_done("b2b_mul", 32'd6, 34);
      start_op("b2b_divu", 3'd5, 32'd9, 32'd3);
      wait_done("b2b_divu", 32'd3, 34);
      next_cycle();
      chk("b2b_done_pulse", {31'b0, done}, 32'd0);

      for (int i = 0; i < 40; i++) begin
         rf   = 3'($urandom_range(0, 7));
         mode = $urandom_range(0, 5);
         rx   = $urandom;
         ry   = $urandom;
         if (mode == 0) ry = 32'd0;
         else if (mode == 1) begin rx = 32'h80000000; ry = 32'hFFFFFFFF; end
         else if (mode == 2) begin rx = $urandom_range(0, 300); ry = $urandom_range(1, 20); end
         if ($urandom_range(0, 1) == 1) next_cycle();
         start_op($sformatf("rnd%0d", i), rf, rx, ry);
         wait_done($sformatf("rnd%0d", i), ref_model(rf, rx, ry), ref_latency(rf, rx, ry));
      end
      next_cycle();

      // Reset in the middle of a multiply
      start_op("rst_mid", 3'd3, 32'hDEADBEEF, 32'h12345678);
      @(posedge clk);
      @(negedge clk);
      #1;
      start = 1'b0;
      repeat (5) next_cycle();
      rst = 1'b1;
      next_cycle();
      chk("rst_mid_busy", {31'b0, busy}, 32'd0);
      chk("rst_mid_done", {31'b0, done}, 32'd0);
      chk("rst_mid_result", result, 32'd0);
      rst = 1'b0;
      next_cycle();
      $display("reset mid-op: result=%h", result);

      start_op("post_rst", 3'd5, 32'd9, 32'd3);
      wait_done("post_rst", 32'd3, 34);
      next_cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
